// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode decoupling queue: extracts the 32-bit instruction from a fetched
// 64-bit word, tags misalign/fault, and presents entries in order to decode.
module fetch_inst_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_pc,
  input  logic [63:0]                in_rdata,
  input  logic                       in_fault,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_misalign,
  output logic                       out_fault,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                flush_drops
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        misalign;
    logic        fault;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     drops_q, drops_d;
  logic [32:0]     drops_sum;
  logic            push, pop;
  entry_t          in_entry, head;

  always_comb begin
    in_ready  = !reset && !flush && (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;

    in_entry.pc       = in_pc;
    in_entry.misalign = (in_pc[1:0] != 2'b00);
    in_entry.fault    = in_fault;
    if (in_entry.misalign || in_fault)
      in_entry.inst = NOP_INST;
    else
      in_entry.inst = in_pc[2] ? in_rdata[63:32] : in_rdata[31:0];

    head = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    drops_sum = {1'b0, drops_q} + 33'(count_q);

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flush overrides any push/pop decided above and tallies discarded entries.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drops_d  = drops_sum[32] ? '1 : drops_sum[31:0];
    end
  end

  always_comb begin
    out_pc       = out_valid ? head.pc       : '0;
    out_inst     = out_valid ? head.inst     : '0;
    out_misalign = out_valid ? head.misalign : 1'b0;
    out_fault    = out_valid ? head.fault    : 1'b0;
    count        = count_q;
    flush_drops  = drops_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_inst_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_rdata;
  logic        in_fault;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;
  logic        out_fault;
  logic [$clog2(DEPTH):0] count;
  logic [31:0] flush_drops;

  fetch_inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rdata(in_rdata),
    .in_fault(in_fault), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_misalign(out_misalign), .out_fault(out_fault),
    .count(count), .flush_drops(flush_drops)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t        sb[$];
  longint      m_drops = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input logic [63:0] pc, input logic [63:0] rdata,
                                    input logic flt);
    exp_t e;
    e.pc  = pc;
    e.mis = (pc % 4) != 0;
    e.flt = flt;
    if (e.mis || flt) e.inst = NOP;
    else if ((pc / 4) % 2 == 1) e.inst = rdata >> 32;
    else e.inst = rdata & 64'hFFFF_FFFF;
    return e;
  endfunction

  // Monitor: inputs are stable at the falling edge; compare, then advance the model.
  int   m_n;
  logic m_rdy;
  exp_t m_head;
  always @(negedge clock) begin
    m_n   = sb.size();
    m_rdy = !reset && !flush && (m_n != DEPTH);
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_n != 0});
    chk("count", 64'(count), 64'(m_n));
    chk("flush_drops", 64'(flush_drops), 64'(m_drops));
    if (m_n != 0) begin
      m_head = sb[0];
      chk("out_pc", out_pc, m_head.pc);
      chk("out_inst", 64'(out_inst), 64'(m_head.inst));
      chk("out_misalign", {63'd0, out_misalign}, {63'd0, m_head.mis});
      chk("out_fault", {63'd0, out_fault}, {63'd0, m_head.flt});
    end else begin
      chk("idle_out", {out_pc[62:0], out_misalign}, 64'd0);
      chk("idle_inst_fault", {31'd0, out_inst, out_fault}, 64'd0);
    end
    if (reset) begin
      sb.delete();
      m_drops = 0;
    end else if (flush) begin
      m_drops = m_drops + m_n;
      if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
      sb.delete();
    end else begin
      if (m_n != 0 && out_ready) void'(sb.pop_front());
      if (in_valid && m_n != DEPTH) sb.push_back(make_exp(in_pc, in_rdata, in_fault));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] rd,
                       input logic flt, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_rdata  = rd;
    in_fault  = flt;
    out_ready = ordy;
    flush     = fl;
  endtask

  localparam logic [63:0] RD1 = 64'h1111_1111_0000_0513;

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;

    // Basic push, low-half extraction
    drive(1, 64'h8000_0000, RD1, 0, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0, 0);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_inst", 64'(out_inst), 64'h0000_0513);
    chk("t1_pc", out_pc, 64'h8000_0000);
    chk("t1_count", 64'(count), 64'd1);

    // High half and misaligned
    drive(1, 64'h8000_0004, RD1, 0, 1, 0);
    tick();
    chk("t2_inst_hi", 64'(out_inst), 64'h1111_1111);
    drive(1, 64'h8000_0002, RD1, 0, 1, 0);
    tick();
    chk("t2_inst_nop", 64'(out_inst), 64'h0000_0013);
    chk("t2_misalign", {63'd0, out_misalign}, 64'd1);
    drive(0, '0, '0, 0, 1, 0);
    tick();
    chk("t2_empty", 64'(count), 64'd0);

    // Fill, reject when full even with a pop, then drain
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h1000 + 64'(4 * i), {$urandom, $urandom}, 0, 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0, 0);
    #1;
    chk("t3_full_count", 64'(count), 64'd4);
    chk("t3_full_ready", {63'd0, in_ready}, 64'd0);
    drive(1, 64'h2000, {$urandom, $urandom}, 0, 1, 0);
    #1;
    chk("t3_ready_with_pop", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t3_reject", 64'(count), 64'd3);
    drive(0, '0, '0, 0, 1, 0);
    repeat (3) tick();
    chk("t3_drained", 64'(count), 64'd0);

    // Streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h3000 + 64'(4 * i), {$urandom, $urandom}, 0, 1, 0);
      tick();
      chk("t4_stream_count", 64'(count), 64'd1);
    end
    drive(0, '0, '0, 0, 1, 0);
    tick();

    // Flush with 3 held entries and an incoming word
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h4000 + 64'(4 * i), {$urandom, $urandom}, 0, 0, 0);
      tick();
    end
    drive(1, 64'h5000, {$urandom, $urandom}, 0, 1, 1);
    #1;
    chk("t5_flush_ready", {63'd0, in_ready}, 64'd0);
    tick();
    drive(0, '0, '0, 0, 0, 0);
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_drops", 64'(flush_drops), 64'd3);
    drive(1, 64'h6000, {$urandom, $urandom}, 0, 0, 0);
    tick();
    chk("t5_refill_pc", out_pc, 64'h6000);
    drive(0, '0, '0, 0, 1, 0);
    tick();

    // Access fault, then reset with entries held
    drive(1, 64'h8000_0010, RD1, 1, 0, 0);
    tick();
    chk("t6_fault", {63'd0, out_fault}, 64'd1);
    chk("t6_inst", 64'(out_inst), 64'h0000_0013);
    drive(1, 64'h8000_0014, RD1, 0, 0, 0);
    tick();
    chk("t6_held", 64'(count), 64'd2);
    drive(0, '0, '0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_drops", 64'(flush_drops), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      tick();
    end
    reset = 1'b0;
    drive(0, '0, '0, 0, 1, 0);
    repeat (DEPTH + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
